// File: rtl/phy_reset_seq.sv
// Power-up and restart sequencer for the RTL8211EG hardware reset pin.
// Holds phy_rstn low for RST_LEN cycles, then waits WAIT_LEN cycles before reporting ready.
`timescale 1ns/1ps
module phy_reset_seq #(
    parameter int RST_LEN  = 500000,
    parameter int WAIT_LEN = 1500000,
    parameter int CNT_W    = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sreset,
    input  logic       block,
    input  logic       csr_pr,
    output logic       phy_rstn,
    output logic       phy_rdy,
    output logic       busy,
    output logic       done,
    output logic [3:0] rcnt
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT,
        ST_READY
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             restart;
    logic             phy_rstn_next;
    logic             phy_rdy_next;
    logic             busy_next;
    logic             done_next;

    // A soft reset always restarts; a CSR request only counts while no soft reset is pending.
    assign restart = sreset | (csr_pr & ~block);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ASSERT;
            cnt   <= '0;
            rcnt  <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (restart && rcnt != 4'hF) begin
                rcnt <= rcnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        if (restart) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == RST_LAST) begin
                        state_next = ST_WAIT;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state_next = ST_READY;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    state_next = ST_READY;
                end
                default: begin
                    state_next = ST_ASSERT;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they land in flops aligned with the state register.
    always_comb begin
        phy_rstn_next = (state_next != ST_ASSERT);
        busy_next     = (state_next != ST_READY);
        phy_rdy_next  = (state_next == ST_READY);
        done_next     = (state_next == ST_READY) && (state != ST_READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phy_rstn <= 1'b0;
            busy     <= 1'b1;
            phy_rdy  <= 1'b0;
            done     <= 1'b0;
        end else begin
            phy_rstn <= phy_rstn_next;
            busy     <= busy_next;
            phy_rdy  <= phy_rdy_next;
            done     <= done_next;
        end
    end

endmodule

// File: doc/phy_reset_seq.md
PHY_RESET_SEQ -- requirements
Module: phy_reset_seq

Interface
REQ-001 SHALL have parameter RST_LEN, default 500000, meaning cycles phy_rstn is held low (10 ms at 50 MHz); legal range 2..2^CNT_W.
REQ-002 SHALL have parameter WAIT_LEN, default 1500000, meaning cycles from phy_rstn release to phy_rdy (30 ms at 50 MHz); legal range 2..2^CNT_W.
REQ-003 SHALL have parameter CNT_W, default 22, meaning width of the shared cycle counter.
REQ-004 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sreset  input  1  level soft reset from the soft reset stage; restarts the PHY sequence.
REQ-007 SHALL have port block  input  1  soft reset pending flag from the soft reset stage; blocks new CSR requests.
REQ-008 SHALL have port csr_pr  input  1  one-cycle PHY reset request strobe from the CSR write decode.
REQ-009 SHALL have port phy_rstn  output  1  registered active-low hardware reset to the RTL8211EG.
REQ-010 SHALL have port phy_rdy  output  1  registered; high only in READY.
REQ-011 SHALL have port busy  output  1  registered; high in ASSERT and WAIT.
REQ-012 SHALL have port done  output  1  registered one-cycle pulse on entry to READY.
REQ-013 SHALL have port rcnt  output  4  saturating count of accepted restart requests.

Function
REQ-014 SHALL implement states ASSERT, WAIT, READY plus a CNT_W-bit counter cnt.
REQ-015 In ASSERT, each edge: cnt == RST_LEN-1 -> WAIT with cnt=0; else cnt+1.
REQ-016 In WAIT, each edge: cnt == WAIT_LEN-1 -> READY with cnt=0; else cnt+1.
REQ-017 In READY, cnt SHALL hold 0 and the state SHALL stay READY until a restart.
REQ-018 A restart SHALL be sreset=1 (any state, regardless of block) or csr_pr=1 with block=0 (any state).
REQ-019 A restart sampled at edge E SHALL set state ASSERT, cnt=0 at E; phy_rstn low after E, high again after edge E+RST_LEN.
REQ-020 phy_rdy SHALL rise after edge E+RST_LEN+WAIT_LEN, with done high for exactly that one cycle.
REQ-021 Restart SHALL win over a simultaneous terminal-count transition.
REQ-022 Restart in ASSERT or WAIT SHALL re-arm with cnt=0, giving a full RST_LEN low period and a full WAIT_LEN wait.
REQ-023 Sustained sreset=1 SHALL hold ASSERT with cnt=0 and phy_rstn=0; the sequence runs from the edge where sreset is sampled 0.
REQ-024 csr_pr with block=1 SHALL be dropped, with no state change and no rcnt change.
REQ-025 rcnt SHALL increment by 1 per edge on which a restart is sampled, and SHALL saturate at 15.
REQ-026 Outputs SHALL be decoded from registered next-state: phy_rstn = (state != ASSERT), busy = (state != READY), phy_rdy = (state == READY).

Reset
REQ-027 While rst=1: state ASSERT, cnt=0, phy_rstn=0, busy=1, phy_rdy=0, done=0, rcnt=0.
REQ-028 After rst release: phy_rstn rises after edge RST_LEN; phy_rdy and done after edge RST_LEN+WAIT_LEN; rcnt stays 0.
REQ-029 rst asserted mid-sequence SHALL immediately force the REQ-027 values, without waiting for a clock edge.

Verification (RST_LEN=4, WAIT_LEN=6)
REQ-030 Power-up: release rst -> phy_rstn=0 for edges 1-3, 1 after edge 4; phy_rdy=1 and done=1 after edge 10; done=0 after edge 11.
REQ-031 CSR request: in READY, csr_pr=1 at edge E with block=0 -> phy_rstn=0 after E, 1 after E+4; phy_rdy after E+10; rcnt=1.
REQ-032 Blocked request: csr_pr=1 with block=1 in READY -> no change to state, phy_rdy or rcnt.
REQ-033 Re-arm: sreset pulse at WAIT cnt=3 -> phy_rstn low 4 more cycles; phy_rdy 10 cycles after the pulse edge; rcnt+1.
REQ-034 Collision/saturation: csr_pr on ASSERT terminal edge -> stays ASSERT, cnt=0; 20 accepted requests -> rcnt=15.
REQ-035 Async reset: rst pulse shorter than one clock period in READY -> phy_rstn=0, phy_rdy=0, rcnt=0 before the next edge.
